// File: rtl/jogo_pkg.sv
// Shared constants for the memory game: FSM state codes shown on the hex display
// and the display/timeout lengths the datapath counters are sized for.
package jogo_pkg;

  typedef enum logic [3:0] {
    inicial        = 4'h0,
    preparacao     = 4'h1,
    inicio_rodada  = 4'h2,
    mostra_dado    = 4'h3,
    zera_exibicao  = 4'h4,
    conta_exibicao = 4'h5,
    inicio_jogada  = 4'h6,
    espera_jogada  = 4'h7,
    registra       = 4'h8,
    comparacao     = 4'h9,
    proxima_jogada = 4'hA,
    proxima_rodada = 4'hB,
    fim_acertou    = 4'hC,
    fim_errou      = 4'hD,
    fim_timeout    = 4'hE
  } estado_t;

  // Cycle counts at the 1 kHz system clock.
  localparam int TEMPO_EXIBICAO = 2000;
  localparam int TEMPO_TIMEOUT  = 5000;

endpackage

// File: rtl/unidade_controle.sv
// Moore control unit for the memory game: replays the stored sequence, collects
// presses, compares them and reports win, loss or timeout.
module unidade_controle
  import jogo_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       fimRodada,
  input  logic       fimTotal,
  input  logic       igual,
  input  logic       fimC,
  input  logic       jogada_feita,
  input  logic       fimTimeout,
  input  logic       fimExibicao,
  input  logic       configTimeout_reg,
  output logic       zeraCL,
  output logic       contaCL,
  output logic       registraModo,
  output logic       zeraC,
  output logic       contaC,
  output logic       escreve,
  output logic       zeraR,
  output logic       registraR,
  output logic       contaTimeout,
  output logic       zeraTimeout,
  output logic       contaExibicao,
  output logic       zeraExibicao,
  output logic       resetEdgeDetector,
  output logic       seletorLedsBM,
  output logic       mostraLeds,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  estado_t state;
  estado_t next_state;

  // fimC is part of the datapath status bundle but no transition depends on it.
  logic unused_fimc;
  assign unused_fimc = fimC;

  always_ff @(posedge clock) begin
    if (reset) state <= inicial;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      inicial:        if (iniciar) next_state = preparacao;
      preparacao:     next_state = inicio_rodada;
      inicio_rodada:  next_state = mostra_dado;
      mostra_dado:    if (fimExibicao) next_state = zera_exibicao;
      zera_exibicao:  next_state = fimRodada ? inicio_jogada : conta_exibicao;
      conta_exibicao: next_state = mostra_dado;
      inicio_jogada:  next_state = espera_jogada;
      // A press in the same cycle as the timeout still counts as a press.
      espera_jogada: begin
        if (jogada_feita)                         next_state = registra;
        else if (fimTimeout && configTimeout_reg) next_state = fim_timeout;
      end
      registra:       next_state = comparacao;
      comparacao: begin
        if (!igual)         next_state = fim_errou;
        else if (!fimRodada) next_state = proxima_jogada;
        else if (fimTotal)  next_state = fim_acertou;
        else                next_state = proxima_rodada;
      end
      proxima_jogada: next_state = espera_jogada;
      proxima_rodada: next_state = inicio_rodada;
      fim_acertou, fim_errou, fim_timeout:
                      if (iniciar) next_state = preparacao;
      default:        next_state = inicial;
    endcase
  end

  always_comb begin
    zeraCL            = 1'b0;
    contaCL           = 1'b0;
    registraModo      = 1'b0;
    zeraC             = 1'b0;
    contaC            = 1'b0;
    escreve           = 1'b0;
    zeraR             = 1'b0;
    registraR         = 1'b0;
    contaTimeout      = 1'b0;
    zeraTimeout       = 1'b0;
    contaExibicao     = 1'b0;
    zeraExibicao      = 1'b0;
    resetEdgeDetector = 1'b0;
    seletorLedsBM     = 1'b0;
    mostraLeds        = 1'b0;
    pronto            = 1'b0;
    acertou           = 1'b0;
    errou             = 1'b0;
    timeout           = 1'b0;
    case (state)
      preparacao: begin
        zeraCL            = 1'b1;
        zeraC             = 1'b1;
        zeraR             = 1'b1;
        registraModo      = 1'b1;
        zeraTimeout       = 1'b1;
        zeraExibicao      = 1'b1;
        resetEdgeDetector = 1'b1;
      end
      inicio_rodada: begin
        zeraC        = 1'b1;
        zeraExibicao = 1'b1;
      end
      mostra_dado: begin
        seletorLedsBM = 1'b1;
        mostraLeds    = 1'b1;
        contaExibicao = 1'b1;
      end
      zera_exibicao:  zeraExibicao = 1'b1;
      conta_exibicao: contaC = 1'b1;
      inicio_jogada: begin
        zeraC       = 1'b1;
        zeraTimeout = 1'b1;
        zeraR       = 1'b1;
      end
      // LEDs echo the buttons here; the timer only runs when timeout is enabled.
      espera_jogada: begin
        mostraLeds   = 1'b1;
        contaTimeout = configTimeout_reg;
      end
      registra: begin
        registraR   = 1'b1;
        zeraTimeout = 1'b1;
      end
      proxima_jogada: contaC  = 1'b1;
      proxima_rodada: contaCL = 1'b1;
      fim_acertou: begin
        pronto  = 1'b1;
        acertou = 1'b1;
      end
      fim_errou: begin
        pronto = 1'b1;
        errou  = 1'b1;
      end
      fim_timeout: begin
        pronto  = 1'b1;
        timeout = 1'b1;
      end
      default: ;
    endcase
  end

  assign db_estado = state;

endmodule

// File: tb/tb_unidade_controle.sv
// Directed bench for unidade_controle: walks the FSM through win, wrong press,
// timeout, disabled timeout, press/timeout collision and mid-game reset.
module tb_unidade_controle;
  import jogo_pkg::*;

  logic clock = 1'b0;
  logic reset, iniciar, fimRodada, fimTotal, igual, fimC;
  logic jogada_feita, fimTimeout, fimExibicao, configTimeout_reg;
  logic zeraCL, contaCL, registraModo, zeraC, contaC, escreve, zeraR, registraR;
  logic contaTimeout, zeraTimeout, contaExibicao, zeraExibicao, resetEdgeDetector;
  logic seletorLedsBM, mostraLeds, pronto, acertou, errou, timeout;
  logic [3:0] db_estado;

  int tests = 0;
  int failures = 0;

  always #5 clock = ~clock;

  unidade_controle dut (
    .clock(clock), .reset(reset), .iniciar(iniciar),
    .fimRodada(fimRodada), .fimTotal(fimTotal), .igual(igual), .fimC(fimC),
    .jogada_feita(jogada_feita), .fimTimeout(fimTimeout), .fimExibicao(fimExibicao),
    .configTimeout_reg(configTimeout_reg),
    .zeraCL(zeraCL), .contaCL(contaCL), .registraModo(registraModo), .zeraC(zeraC),
    .contaC(contaC), .escreve(escreve), .zeraR(zeraR), .registraR(registraR),
    .contaTimeout(contaTimeout), .zeraTimeout(zeraTimeout), .contaExibicao(contaExibicao),
    .zeraExibicao(zeraExibicao), .resetEdgeDetector(resetEdgeDetector),
    .seletorLedsBM(seletorLedsBM), .mostraLeds(mostraLeds), .pronto(pronto),
    .acertou(acertou), .errou(errou), .timeout(timeout), .db_estado(db_estado)
  );

  // Output vector bit positions, MSB first in port order.
  localparam logic [18:0] ZCL = 19'h1 << 18, CCL = 19'h1 << 17, RMO = 19'h1 << 16;
  localparam logic [18:0] ZC  = 19'h1 << 15, CC  = 19'h1 << 14, ZR  = 19'h1 << 12;
  localparam logic [18:0] RR  = 19'h1 << 11, CT  = 19'h1 << 10, ZT  = 19'h1 << 9;
  localparam logic [18:0] CE  = 19'h1 << 8,  ZE  = 19'h1 << 7,  RED = 19'h1 << 6;
  localparam logic [18:0] SEL = 19'h1 << 5,  ML  = 19'h1 << 4,  PR  = 19'h1 << 3;
  localparam logic [18:0] AC  = 19'h1 << 2,  ER  = 19'h1 << 1,  TO  = 19'h1;

  localparam logic [18:0] O0 = 19'h0;
  localparam logic [18:0] O1 = ZCL | ZC | ZR | RMO | ZT | ZE | RED;
  localparam logic [18:0] O2 = ZC | ZE;
  localparam logic [18:0] O3 = SEL | ML | CE;
  localparam logic [18:0] O4 = ZE;
  localparam logic [18:0] O5 = CC;
  localparam logic [18:0] O6 = ZC | ZT | ZR;
  localparam logic [18:0] O7 = ML;
  localparam logic [18:0] O8 = RR | ZT;
  localparam logic [18:0] O9 = 19'h0;
  localparam logic [18:0] OA = CC;
  localparam logic [18:0] OB = CCL;
  localparam logic [18:0] OC = PR | AC;
  localparam logic [18:0] OD = PR | ER;
  localparam logic [18:0] OE = PR | TO;

  logic [18:0] outs;
  assign outs = {zeraCL, contaCL, registraModo, zeraC, contaC, escreve, zeraR, registraR,
                 contaTimeout, zeraTimeout, contaExibicao, zeraExibicao, resetEdgeDetector,
                 seletorLedsBM, mostraLeds, pronto, acertou, errou, timeout};

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic checkOutput(input string tag, input estado_t exp_state, input logic [18:0] exp_outs);
    tests++;
    assert (db_estado === exp_state) else begin
      failures++;
      $error("[TB] FAIL %s state: got %h expected %h", tag, db_estado, exp_state);
    end
    tests++;
    assert (outs === exp_outs) else begin
      failures++;
      $error("[TB] FAIL %s outputs: got %b expected %b", tag, outs, exp_outs);
    end
  endtask

  task automatic applyStimulus(input string tag, input estado_t exp_state, input logic [18:0] exp_outs);
    tick();
    checkOutput(tag, exp_state, exp_outs);
  endtask

  initial begin
    reset = 1'b1; iniciar = 1'b1; fimRodada = 1'b0; fimTotal = 1'b0; igual = 1'b0;
    fimC = 1'b0; jogada_feita = 1'b0; fimTimeout = 1'b0; fimExibicao = 1'b0;
    configTimeout_reg = 1'b0;

    // Reset wins over iniciar
    applyStimulus("reset_a", inicial, O0);
    applyStimulus("reset_b", inicial, O0);
    reset = 1'b0;
    applyStimulus("prep", preparacao, O1);
    iniciar = 1'b0;
    applyStimulus("ini_rodada", inicio_rodada, O2);
    applyStimulus("mostra", mostra_dado, O3);
    applyStimulus("mostra_hold", mostra_dado, O3);
    fimExibicao = 1'b1;
    applyStimulus("zera_exib", zera_exibicao, O4);
    fimExibicao = 1'b0;
    applyStimulus("conta_exib", conta_exibicao, O5);
    applyStimulus("mostra2", mostra_dado, O3);
    fimExibicao = 1'b1;
    applyStimulus("zera_exib2", zera_exibicao, O4);
    fimExibicao = 1'b0; fimRodada = 1'b1;
    applyStimulus("ini_jogada", inicio_jogada, O6);
    applyStimulus("espera", espera_jogada, O7);
    applyStimulus("espera_hold", espera_jogada, O7);

    // Round 0 correct, not last round
    jogada_feita = 1'b1;
    applyStimulus("registra", registra, O8);
    jogada_feita = 1'b0; igual = 1'b1; fimRodada = 1'b1; fimTotal = 1'b0;
    applyStimulus("comp", comparacao, O9);
    applyStimulus("prox_rodada", proxima_rodada, OB);
    applyStimulus("ini_rodada2", inicio_rodada, O2);
    fimExibicao = 1'b1;
    applyStimulus("mostra3", mostra_dado, O3);
    applyStimulus("zera_exib3", zera_exibicao, O4);
    fimExibicao = 1'b0;
    applyStimulus("ini_jogada2", inicio_jogada, O6);
    applyStimulus("espera2", espera_jogada, O7);

    // Two presses in the final round, second one wins the game
    jogada_feita = 1'b1; fimRodada = 1'b0;
    applyStimulus("registra2", registra, O8);
    jogada_feita = 1'b0;
    applyStimulus("comp2", comparacao, O9);
    applyStimulus("prox_jogada", proxima_jogada, OA);
    applyStimulus("espera3", espera_jogada, O7);
    jogada_feita = 1'b1;
    applyStimulus("registra3", registra, O8);
    jogada_feita = 1'b0; fimRodada = 1'b1; fimTotal = 1'b1;
    applyStimulus("comp3", comparacao, O9);
    applyStimulus("acertou", fim_acertou, OC);
    applyStimulus("acertou_hold", fim_acertou, OC);

    // Restart from the win and lose with a wrong press
    iniciar = 1'b1;
    applyStimulus("restart1", preparacao, O1);
    iniciar = 1'b0; fimExibicao = 1'b1; fimRodada = 1'b1; fimTotal = 1'b0;
    applyStimulus("restart1_2", inicio_rodada, O2);
    applyStimulus("r1_mostra", mostra_dado, O3);
    applyStimulus("r1_zera", zera_exibicao, O4);
    applyStimulus("r1_inij", inicio_jogada, O6);
    applyStimulus("r1_espera", espera_jogada, O7);
    fimExibicao = 1'b0; igual = 1'b0; jogada_feita = 1'b1;
    applyStimulus("err_reg", registra, O8);
    jogada_feita = 1'b0;
    applyStimulus("err_comp", comparacao, O9);
    applyStimulus("errou", fim_errou, OD);

    // Timeout enabled: no press, timer expires
    iniciar = 1'b1;
    applyStimulus("restart2", preparacao, O1);
    iniciar = 1'b0; fimExibicao = 1'b1; configTimeout_reg = 1'b1;
    applyStimulus("r2_ini", inicio_rodada, O2);
    applyStimulus("r2_mostra", mostra_dado, O3);
    applyStimulus("r2_zera", zera_exibicao, O4);
    applyStimulus("r2_inij", inicio_jogada, O6);
    applyStimulus("r2_espera", espera_jogada, O7 | CT);
    fimExibicao = 1'b0; fimTimeout = 1'b1;
    applyStimulus("timeout", fim_timeout, OE);
    fimTimeout = 1'b0;

    // Press and timeout in the same cycle: the press wins
    iniciar = 1'b1;
    applyStimulus("restart3", preparacao, O1);
    iniciar = 1'b0; fimExibicao = 1'b1;
    applyStimulus("r3_ini", inicio_rodada, O2);
    applyStimulus("r3_mostra", mostra_dado, O3);
    applyStimulus("r3_zera", zera_exibicao, O4);
    applyStimulus("r3_inij", inicio_jogada, O6);
    applyStimulus("r3_espera", espera_jogada, O7 | CT);
    fimExibicao = 1'b0; fimTimeout = 1'b1; jogada_feita = 1'b1;
    applyStimulus("collision", registra, O8);
    fimTimeout = 1'b0; jogada_feita = 1'b0; igual = 1'b1; fimRodada = 1'b0;
    applyStimulus("r3_comp", comparacao, O9);
    applyStimulus("r3_prox", proxima_jogada, OA);

    // Timeout disabled: an expired timer is ignored
    configTimeout_reg = 1'b0; fimTimeout = 1'b1;
    applyStimulus("no_to_a", espera_jogada, O7);
    applyStimulus("no_to_b", espera_jogada, O7);
    applyStimulus("no_to_c", espera_jogada, O7);
    fimTimeout = 1'b0;

    // Reset mid-game aborts in one cycle and stays idle without iniciar
    reset = 1'b1;
    applyStimulus("mid_reset", inicial, O0);
    reset = 1'b0;
    applyStimulus("idle", inicial, O0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
